multi_interval_timer: RTL

- Avalon-MM slave holding NUM_CH independent down-counting interval timers.
- Each channel has its own period, control, status and snapshot registers.
- A single irq output is the OR of the per-channel interrupts; an extra irq_vec exposes each channel's interrupt separately.
- Used as the system tick and as general-purpose timers beside the Nios II CPU. Successor to the single-channel 16-bit-bus system clock timer.

---
 rtl/multi_interval_timer.sv | 110 +++++++++++
 1 files changed

// File: rtl/multi_interval_timer.sv
// multi_interval_timer: Avalon-MM bank of NUM_CH down-counting interval timers; define MULTI_INTERVAL_TIMER_CASCADE_EN to enable CONTROL.CASC chaining
module multi_interval_timer #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int RESET_PERIOD = 49999,
  parameter int ADDR_W       = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec
);
`ifdef MULTI_INTERVAL_TIMER_CASCADE_EN
  localparam bit CASC_EN = 1'b1;
`else
  localparam bit CASC_EN = 1'b0;
`endif
  localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(RESET_PERIOD);
  logic [NUM_CH-1:0][CNT_W-1:0] period_q, period_d, cnt_q, cnt_d, snap_q, snap_d;
  logic [NUM_CH-1:0][4:0] ctrl_q, ctrl_d;
  logic [NUM_CH-1:0] run_q, run_d, to_q, to_d, reload_q, reload_d, zero_q, zero_d;
  logic [NUM_CH-1:0] ev, tick, sel;
  logic [31:0] readdata_q, readdata_d;
  logic [ADDR_W-1:0] ch;
  logic [1:0] reg_a;
  logic wr;
  assign ch = address >> 2;
  assign reg_a = address[1:0];
  assign wr = chipselect && !write_n;
  assign readdata = readdata_q;
  assign irq = |irq_vec;
  always_comb begin
    ev = '0;
    sel = '0;
    irq_vec = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ev[i] = (cnt_q[i] == '0) && !zero_q[i];
      sel[i] = wr && (ch == ADDR_W'(i));
      irq_vec[i] = to_q[i] && ctrl_q[i][0];
    end
  end
  // a cascaded channel advances only on its lower neighbour's timeout event
  always_comb begin
    tick = '1;
    for (int i = 1; i < NUM_CH; i++) tick[i] = (CASC_EN && ctrl_q[i][4]) ? ev[i-1] : 1'b1;
  end
  always_comb begin
    period_d = period_q;
    cnt_d = cnt_q;
    snap_d = snap_q;
    ctrl_d = ctrl_q;
    run_d = run_q;
    to_d = '0;
    zero_d = '0;
    reload_d = '0;
    readdata_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      zero_d[i] = cnt_q[i] == '0;
      reload_d[i] = sel[i] && reg_a == 2'd2;
      to_d[i] = (sel[i] && reg_a == 2'd0) ? 1'b0 : (to_q[i] || ev[i]);
      if (reload_d[i]) period_d[i] = writedata[CNT_W-1:0];
      if (sel[i] && reg_a == 2'd3) snap_d[i] = cnt_q[i];
      if (run_q[i] && tick[i]) begin
        cnt_d[i] = (cnt_q[i] == '0) ? period_q[i] : cnt_q[i] - 1'b1;
        if (cnt_q[i] == '0 && !ctrl_q[i][1]) run_d[i] = 1'b0;
      end
      if (sel[i] && reg_a == 2'd1) begin
        ctrl_d[i] = {writedata[4] && CASC_EN && (i != 0), writedata[3:0]};
        run_d[i] = writedata[2] || (run_d[i] && !writedata[3]);
      end
      // the cycle after a PERIOD write reloads and stops, beating any START
      if (reload_q[i]) begin
        cnt_d[i] = period_q[i];
        run_d[i] = 1'b0;
      end
      if (ch == ADDR_W'(i))
        readdata_d = reg_a == 2'd0 ? 32'({run_q[i], to_q[i]}) :
                     reg_a == 2'd1 ? 32'(ctrl_q[i]) :
                     reg_a == 2'd2 ? 32'(period_q[i]) : 32'(snap_q[i]);
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q <= {NUM_CH{RST_CNT}};
      cnt_q <= {NUM_CH{RST_CNT}};
      snap_q <= '0;
      ctrl_q <= '0;
      run_q <= '0;
      to_q <= '0;
      reload_q <= '0;
      zero_q <= '0;
      readdata_q <= '0;
    end else begin
      period_q <= period_d;
      cnt_q <= cnt_d;
      snap_q <= snap_d;
      ctrl_q <= ctrl_d;
      run_q <= run_d;
      to_q <= to_d;
      reload_q <= reload_d;
      zero_q <= zero_d;
      readdata_q <= readdata_d;
    end
  end
endmodule
